// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared debounce constants and counter-width helper
package sw_debounce_pkg;

    // Short stability window so simulations settle in a handful of cycles
    localparam int SIM_STABLE = 4;

    // 20 ms at 50 MHz on the board
    localparam int BOARD_STABLE = 1000000;

    // Board counter width: 2**20 > BOARD_STABLE-1
    localparam int BOARD_CNT_W = 20;

    // Smallest width whose range covers 0..stable-1 (never below 1 bit)
    function automatic int cnt_width(input int stable);
        return (stable <= 2) ? 1 : $clog2(stable);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: synchronizer, stability counter and edge strobes for one switch
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = SIM_STABLE,
    parameter int CNT_W         = cnt_width(SIM_STABLE)
) (
    input  logic io_clk,
    input  logic resetn,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Acceptance happens on the cycle the synchronized input has differed long enough
    assign accept = (s2 != clean) && (cnt == LAST);

    // Synchronize, count consecutive differing cycles, then adopt the new level
    always_ff @(posedge io_clk) begin
        if (!resetn) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            cnt   <= (s2 == clean || accept) ? '0 : cnt + 1'b1;
            clean <= accept ? s2 : clean;
            rise  <= accept & s2;
            fall  <= accept & ~s2;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit switch debouncing with a CPU-clearable sticky change flag
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = BOARD_STABLE,
    parameter int CNT_W         = BOARD_CNT_W
) (
    input  logic             io_clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             chg_clr,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    logic [WIDTH-1:0] accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_bit (
            .io_clk(io_clk),
            .resetn(resetn),
            .raw   (sw_raw[i]),
            .clean (sw_clean[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i]),
            .accept(accept[i])
        );
    end

    // Sticky flag set alongside any strobe; a new acceptance beats a same-cycle clear
    always_ff @(posedge io_clk) begin
        if (!resetn) sw_changed <= 1'b0;
        else         sw_changed <= (|accept) | (sw_changed & ~chg_clr);
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed vector table plus hand-written multi-cycle sequences
module tb_sw_debounce;

    logic       io_clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] sw_raw = '0;
    logic       chg_clr = 1'b0;
    logic [9:0] sw_clean;
    logic [9:0] sw_rise;
    logic [9:0] sw_fall;
    logic       sw_changed;

    int total = 0;
    int passed = 0;

    sw_debounce #(.WIDTH(10), .STABLE_CYCLES(4), .CNT_W(3)) dut (
        .io_clk    (io_clk),
        .resetn    (resetn),
        .sw_raw    (sw_raw),
        .chg_clr   (chg_clr),
        .sw_clean  (sw_clean),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    always #5 io_clk = ~io_clk;

    typedef struct {
        logic       rstn;
        logic [9:0] raw;
        logic       clr;
        logic [9:0] clean;
        logic [9:0] rise;
        logic [9:0] fall;
        logic       chg;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rstn, input logic [9:0] raw, input logic clr,
                                input logic [9:0] clean, input logic [9:0] rise,
                                input logic [9:0] fall, input logic chg);
        vec_t v;
        v.rstn = rstn; v.raw = raw; v.clr = clr;
        v.clean = clean; v.rise = rise; v.fall = fall; v.chg = chg;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [9:0] clean, input logic [9:0] rise,
                           input logic [9:0] fall, input logic chg);
        chk({tag, " clean"}, sw_clean, clean);
        chk({tag, " rise"}, sw_rise, rise);
        chk({tag, " fall"}, sw_fall, fall);
        chk({tag, " changed"}, {9'b0, sw_changed}, {9'b0, chg});
    endtask

    initial begin
        // Reset held 3 cycles with all switches high, then release: accept at 6th edge
        for (int i = 0; i < 3; i++) add(0, 10'h3FF, 0, 10'h000, 10'h000, 10'h000, 0);
        for (int i = 0; i < 5; i++) add(1, 10'h3FF, 0, 10'h000, 10'h000, 10'h000, 0);
        add(1, 10'h3FF, 0, 10'h3FF, 10'h3FF, 10'h000, 1);
        add(1, 10'h3FF, 0, 10'h3FF, 10'h000, 10'h000, 1);
        add(1, 10'h3FF, 1, 10'h3FF, 10'h000, 10'h000, 0);
        // Back to all-zero, then a clean step on bit 0
        add(0, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0);
        for (int i = 0; i < 5; i++) add(1, 10'h001, 0, 10'h000, 10'h000, 10'h000, 0);
        add(1, 10'h001, 0, 10'h001, 10'h001, 10'h000, 1);
        add(1, 10'h001, 0, 10'h001, 10'h000, 10'h000, 1);
        add(1, 10'h001, 1, 10'h001, 10'h000, 10'h000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            resetn  = vecs[i].rstn;
            sw_raw  = vecs[i].raw;
            chg_clr = vecs[i].clr;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].clean, vecs[i].rise, vecs[i].fall, vecs[i].chg);
        end
        chg_clr = 0;

        // 3-cycle glitch on bit 3 must be rejected
        for (int e = 1; e <= 10; e++) begin
            sw_raw = (e <= 3) ? 10'h009 : 10'h001;
            tick();
            chk_all($sformatf("glitch e%0d", e), 10'h001, 10'h000, 10'h000, 0);
        end

        // 4-cycle pulse on bit 3: rise at edge 6, fall at edge 10
        for (int e = 1; e <= 12; e++) begin
            sw_raw = (e <= 4) ? 10'h009 : 10'h001;
            tick();
            chk_all($sformatf("pulse e%0d", e), (e >= 6 && e < 10) ? 10'h009 : 10'h001,
                    (e == 6) ? 10'h008 : 10'h000, (e == 10) ? 10'h008 : 10'h000, e >= 6);
        end

        chg_clr = 1;
        tick();
        chg_clr = 0;
        chk("sticky clear", {9'b0, sw_changed}, 10'h000);

        // Bounce on bit 5: 1,0,1,0,1 then hold 1 gives one rise at edge 10
        for (int e = 1; e <= 14; e++) begin
            sw_raw = (e > 5 || e[0]) ? 10'h021 : 10'h001;
            tick();
            chk_all($sformatf("bounce e%0d", e), (e >= 10) ? 10'h021 : 10'h001,
                    (e == 10) ? 10'h020 : 10'h000, 10'h000, e >= 10);
        end

        chg_clr = 1;
        tick();
        chg_clr = 0;
        chk("clear after bounce", {9'b0, sw_changed}, 10'h000);

        // Clear coinciding with a new acceptance on bit 9: set wins
        for (int e = 1; e <= 7; e++) begin
            sw_raw  = 10'h221;
            chg_clr = (e == 6);
            tick();
            chk_all($sformatf("setwins e%0d", e), (e >= 6) ? 10'h221 : 10'h021,
                    (e == 6) ? 10'h200 : 10'h000, 10'h000, e >= 6);
        end
        chg_clr = 0;

        // Reset in the middle of a count on bit 2 discards the partial count
        for (int e = 1; e <= 4; e++) begin
            sw_raw = 10'h225;
            tick();
            chk_all($sformatf("midcount e%0d", e), 10'h221, 10'h000, 10'h000, 1);
        end
        resetn = 0;
        tick();
        chk_all("midcount reset", 10'h000, 10'h000, 10'h000, 0);
        resetn = 1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk_all($sformatf("after reset e%0d", e), (e >= 6) ? 10'h225 : 10'h000,
                    (e == 6) ? 10'h225 : 10'h000, 10'h000, e >= 6);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
